// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmitter (and the future receiver).
//   uart_tx_state_e : transmitter FSM state encoding
//   PAR_*           : values of the PARITY parameter
//   clock_divide()  : clock cycles per bit period (integer divide)
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DONE
    } uart_tx_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    function automatic int clock_divide(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Producer-side handshake of the UART transmitter.
//   start      : producer offers tx_data_in this cycle
//   tx_data_in : word to send, bit 0 first on the line
//   tx_ready   : transmitter accepts a word on this cycle's edge if start is high
// master = producer (FIFO/CPU register), slave = transmitter.
interface uart_tx_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic                 start;
    logic [DATA_BITS-1:0] tx_data_in;
    logic                 tx_ready;

    modport master (output start, output tx_data_in, input tx_ready);
    modport slave  (input start, input tx_data_in, output tx_ready);
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLOCK_DIVIDE-1 and pulses tick on the last count.
//   clk, rst_n : clock, async active-low reset
//   clear      : hold the counter at 0 (idle / between frames)
//   tick       : high in the last cycle of each bit period
module uart_baud_tick #(
    parameter int CLOCK_DIVIDE = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);
    localparam int CNT_W = (CLOCK_DIVIDE > 2) ? $clog2(CLOCK_DIVIDE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLOCK_DIVIDE - 1);

    logic [CNT_W-1:0] count;

    assign tick = !clear && (count == LAST);

    // Wrapping on tick makes every bit period exactly CLOCK_DIVIDE cycles long.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clear || tick)
            count <= '0;
        else
            count <= count + 1'b1;
    end
endmodule

// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter: one frame per accepted word.
// Frame = start bit, DATA_BITS data bits LSB first, optional parity, STOP_BITS stop bits.
//   clk, rst_n : clock, async active-low reset
//   bus        : producer handshake (start, tx_data_in in; tx_ready out)
//   tx         : registered serial line, idle high
//   tx_active  : high while start/data/parity/stop bits are on the line
//   done_tx    : one-cycle pulse right after the last stop bit
// The line outputs are registered from the current state, so they trail the
// state by one cycle: accept at edge N puts the start bit on tx from edge N+1.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 19200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    uart_tx_cfg_if.slave         bus,
    output logic                 tx,
    output logic                 tx_active,
    output logic                 done_tx
);
    localparam int CLOCK_DIVIDE = clock_divide(CLK_FREQ, BAUD_RATE);
    localparam int BIT_W        = $clog2(DATA_BITS);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    if (CLOCK_DIVIDE < 2) begin : g_bad_div
        $error("uart_tx_cfg: CLOCK_DIVIDE must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("uart_tx_cfg: DATA_BITS must be 5..9");
    end
    if (PARITY < PAR_NONE || PARITY > PAR_ODD) begin : g_bad_par
        $error("uart_tx_cfg: PARITY must be 0..2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end

    uart_tx_state_e       state, state_nxt;
    logic [DATA_BITS-1:0] data_q;
    logic [BIT_W-1:0]     bit_idx;
    logic                 stop_cnt;
    logic                 tick;
    logic                 par_bit;
    logic                 accept;

    assign accept       = (state == IDLE) && bus.start;
    assign bus.tx_ready = (state == IDLE);
    // Parity always comes from the captured word, never the live input.
    assign par_bit      = (PARITY == PAR_ODD) ? ~^data_q : ^data_q;

    uart_baud_tick #(.CLOCK_DIVIDE(CLOCK_DIVIDE)) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .clear ((state == IDLE) || (state == DONE)),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (bus.start) state_nxt = START;
            START: if (tick) state_nxt = DATA;
            DATA:  if (tick && bit_idx == LAST_BIT)
                       state_nxt = (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
            uart_pkg::PARITY: if (tick) state_nxt = STOP;
            STOP:  if (tick && stop_cnt == LAST_STOP) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Bit and stop counters wrap back to 0 on their last tick, so they are
    // already clear when the next frame starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q   <= '0;
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
        end else begin
            if (accept)
                data_q <= bus.tx_data_in;
            if (state == DATA && tick)
                bit_idx <= (bit_idx == LAST_BIT) ? '0 : bit_idx + 1'b1;
            if (state == STOP && tick)
                stop_cnt <= (stop_cnt == LAST_STOP) ? 1'b0 : stop_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx        <= 1'b1;
            tx_active <= 1'b0;
            done_tx   <= 1'b0;
        end else begin
            done_tx   <= (state == DONE);
            tx_active <= (state == START) || (state == DATA) ||
                         (state == uart_pkg::PARITY) || (state == STOP);
            case (state)
                START:            tx <= 1'b0;
                DATA:             tx <= data_q[bit_idx];
                uart_pkg::PARITY: tx <= par_bit;
                default:          tx <= 1'b1;
            endcase
        end
    end
endmodule
